fc_weight_fetch: RTL

Read-side sequencer for the fully-connected weight ROMs. It drives the dual-port ROM's `address_a`/`address_b` and streams weight pairs (two 16-bit words per beat) to the FC MAC datapath over a valid/ready interface. It absorbs the ROM's one-cycle registered-read latency and applies downstream backpressure without losing or duplicating words. Each job is a contiguous run of `count` words starting at `base_addr`, wrapping modulo ROM depth.

---
 rtl/fc_weight_fetch.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fc_weight_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fc_weight_fetch                                                |
// | Purpose : Read-side sequencer for the fully-connected weight ROMs.       |
// |           Walks a contiguous, wrapping run of `count` words from         |
// |           `base_addr`, two words per cycle on the dual-port ROM, and     |
// |           streams the pairs to the MAC datapath over valid/ready.        |
// |           A 4-entry output FIFO plus a credit check absorbs the ROM's    |
// |           one-cycle read latency and downstream backpressure.            |
// | Ports   : clock, reset_n (async, active-low)                             |
// |           start, base_addr, count            - job request              |
// |           address_a/address_b, q_a/q_b       - ROM read port            |
// |           out_valid/out_ready, out_a, out_b,                             |
// |           out_b_valid, out_last              - weight-pair stream       |
// |           busy, done                         - job status               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fc_weight_fetch #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0]        c_FIFO_DEPTH = 4'd4;
  localparam logic [ADDR_W:0]   c_CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_CNT_TWO    = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_TWO   = ADDR_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Issue-side registers
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remain;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;

  // Tag pipeline: stage 1 aligns with the address, stage 2 with q_*
  logic r_s1_valid, r_s1_bv, r_s1_last;
  logic r_s2_valid, r_s2_bv, r_s2_last;

  // Output FIFO
  logic [DATA_W-1:0] r_fifo_a    [4];
  logic [DATA_W-1:0] r_fifo_b    [4];
  logic              r_fifo_bv   [4];
  logic              r_fifo_last [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_occ;

  logic r_done;

  // Combinational
  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic [1:0]        w_inflight;
  logic [3:0]        w_credit;
  logic              w_room;
  logic              w_issue;
  logic              w_done_set;
  logic [ADDR_W-1:0] w_cur_ptr;
  logic [ADDR_W:0]   w_cur_remain;
  logic              w_issue_bv;
  logic              w_issue_last;

  assign out_valid   = (r_occ != 3'd0);
  assign w_pop       = out_valid & out_ready;
  assign w_push      = r_s2_valid;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // Every issued pair already owns a FIFO slot: occupancy plus pairs still in
  // the ROM pipe, minus the slot freed this cycle, must leave room.
  assign w_inflight = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};
  assign w_credit   = {1'b0, r_occ} + {2'b00, w_inflight} - {3'b000, w_pop};
  assign w_room     = (w_credit < c_FIFO_DEPTH);

  // The first pair is issued straight from the request inputs so that the
  // first addresses appear in the cycle after start.
  assign w_cur_ptr    = (r_state == ST_IDLE) ? base_addr : r_ptr;
  assign w_cur_remain = (r_state == ST_IDLE) ? count     : r_remain;
  assign w_issue_bv   = (w_cur_remain > c_CNT_ONE);
  assign w_issue_last = (w_cur_remain <= c_CNT_TWO);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_state_next = (count <= c_CNT_TWO) ? ST_DRAIN : ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_remain <= c_CNT_TWO) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_done_set   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Issue datapath, tag pipeline and FIFO bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_remain   <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_bv    <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_bv    <= 1'b0;
      r_s2_last  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_addr_a <= w_cur_ptr;
        // An odd tail reads the same word on both ports; lane b is tagged
        // invalid so the duplicate never reaches the consumer.
        r_addr_b <= w_issue_bv ? (w_cur_ptr + c_ADDR_ONE) : w_cur_ptr;
        r_ptr    <= w_cur_ptr + c_ADDR_TWO;
        r_remain <= w_issue_bv ? (w_cur_remain - c_CNT_TWO) : '0;
      end
      r_s1_valid <= w_issue;
      r_s1_bv    <= w_issue & w_issue_bv;
      r_s1_last  <= w_issue & w_issue_last;
      r_s2_valid <= r_s1_valid;
      r_s2_bv    <= r_s1_bv;
      r_s2_last  <= r_s1_last;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase

      r_done <= w_done_set;
    end
  end

  // FIFO storage needs no reset: every read is gated by occupancy.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr]    <= q_a;
      r_fifo_b[r_wr_ptr]    <= q_b;
      r_fifo_bv[r_wr_ptr]   <= r_s2_bv;
      r_fifo_last[r_wr_ptr] <= r_s2_last;
    end
  end

  assign address_a   = r_addr_a;
  assign address_b   = r_addr_b;
  assign out_a       = out_valid ? r_fifo_a[r_rd_ptr] : '0;
  assign out_b       = out_valid ? r_fifo_b[r_rd_ptr] : '0;
  assign out_b_valid = out_valid & r_fifo_bv[r_rd_ptr];
  assign out_last    = out_valid & w_head_last;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;

endmodule
`default_nettype wire
